// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: line levels, frame size,
// the store address that feeds it, and the serializer state encoding.
package uart_pkg;

  localparam int          UART_DATA_BITS = 8;
  localparam logic        UART_START_LVL = 1'b0;
  localparam logic        UART_STOP_LVL  = 1'b1;
  localparam logic [31:0] UART_TX_ADDR   = 32'hFFFF_FFFC;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when
// empty are ignored, so callers may drive raw strobes.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and level define validity, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by the core's byte-store path; bytes queue in a
// small FIFO and frames go out back to back while the queue is non-empty.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data,
  input  logic                          wEn,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    head;
  logic          empty;
  logic          bit_done;
  logic          pop;

  assign bit_done = (baud_cnt == BAUD_LAST);
  // A pop happens either from idle or on the final stop cycle, which is what
  // keeps consecutive frames contiguous.
  assign pop  = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_done));
  assign busy = (state != ST_IDLE) | (level != '0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wEn),
    .pop   (pop),
    .wdata (data),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // NOTE: tx is assigned from the next-state decision inside this clocked
  // block, so the line changes on the same edge as the state, with no
  // combinational decode driving the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= UART_STOP_LVL;
      overflow <= 1'b0;
    end else begin
      overflow <= wEn & full;
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shreg <= head;
            tx    <= UART_START_LVL;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              tx    <= UART_STOP_LVL;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg <= head;
              tx    <= UART_START_LVL;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line decoder checks frames against a queue of bytes
// that are expected to be accepted; cycle-exact checks cover latency and status.
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int CPB2 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data4 = '0, data2 = '0;
  logic       wen4 = 1'b0, wen2 = 1'b0;
  logic       tx4, busy4, full4, ovf4;
  logic       tx2, busy2, full2, ovf2;
  logic [3:0] level4, level2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] sb[$];
  int         start_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut4 (
    .clk(clk), .rst(rst), .data(data4), .wEn(wen4), .tx(tx4),
    .busy(busy4), .full(full4), .level(level4), .overflow(ovf4)
  );

  uart_tx #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(8)) dut2 (
    .clk(clk), .rst(rst), .data(data2), .wEn(wen2), .tx(tx2),
    .busy(busy2), .full(full2), .level(level2), .overflow(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level c cycles after a single write into an idle block.
  function automatic logic exp_tx(input logic [7:0] b, input int c, input int cpb);
    int t;
    if (c < 2) return 1'b1;
    t = c - 2;
    if (t < cpb) return 1'b0;
    if (t < 9 * cpb) return b[3'(t / cpb - 1)];
    return 1'b1;
  endfunction

  // Bit slot sampled at offset cnt into a frame: 0 start, 1..8 data, 9 stop.
  function automatic int slot(input int cnt, input int cpb);
    if (cnt < cpb / 2) return -1;
    if ((cnt - cpb / 2) % cpb != 0) return -1;
    return (cnt - cpb / 2) / cpb;
  endfunction

  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = '0;

  always @(negedge clk) begin
    if (rst) begin
      rx_active <= 1'b0;
    end else if (!rx_active) begin
      if (tx4 == 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
        start_q.push_back(cyc);
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (slot(rx_cnt, CPB) == 0) begin
        check("rx_start_bit", tx4, 1'b0);
      end else if (slot(rx_cnt, CPB) >= 1 && slot(rx_cnt, CPB) <= 8) begin
        rx_byte[3'(slot(rx_cnt, CPB) - 1)] <= tx4;
      end else if (slot(rx_cnt, CPB) == 9) begin
        check("rx_stop_bit", tx4, 1'b1);
        check("rx_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) check("rx_byte", rx_byte, sb.pop_front());
        rx_active <= 1'b0;
      end
    end
  end

  task automatic wait_idle4();
    for (int i = 0; i < 2000 && busy4; i++) tick();
    check("idle4_timeout", busy4, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_tx", tx4, 1'b1);
    check("rst_busy", busy4, 1'b0);
    check("rst_full", full4, 1'b0);
    check("rst_level", level4, 0);
    check("rst_ovf", ovf4, 1'b0);
    check("rst_tx2", tx2, 1'b1);

    // Single byte: exact waveform, busy window and first-cycle level.
    for (int c = 0; c <= 10 * CPB + 2; c++) begin
      if (c == 0) begin
        wen4 = 1'b1; data4 = 8'hA5; sb.push_back(8'hA5);
      end else begin
        wen4 = 1'b0;
      end
      check("t1_tx", tx4, exp_tx(8'hA5, c, CPB));
      check("t1_busy", busy4, (c >= 1 && c <= 10 * CPB + 1));
      if (c == 1) check("t1_level", level4, 1);
      if (c == 2) check("t1_level_popped", level4, 0);
      tick();
    end
    wait_idle4();

    // Three queued bytes: frames must start exactly 10*CPB apart.
    begin
      int base;
      logic [7:0] bytes [3];
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
      start_q.delete();
      base = cyc;
      for (int c = 0; c <= 30 * CPB + 2; c++) begin
        if (c < 3) begin
          wen4 = 1'b1; data4 = bytes[c]; sb.push_back(bytes[c]);
        end else begin
          wen4 = 1'b0;
        end
        if (c >= 2) check("t2_busy", busy4, (c <= 30 * CPB + 1));
        tick();
      end
      check("t2_frames", start_q.size(), 3);
      for (int i = 0; i < 3 && i < start_q.size(); i++)
        check("t2_start_cycle", start_q[i], base + 2 + 10 * CPB * i);
    end
    wait_idle4();

    // Overfill: 0x09 dropped at full; then a write coincident with a pop.
    for (int c = 0; c <= 10 * CPB + 3; c++) begin
      wen4 = 1'b0;
      if (c <= 9) begin
        wen4 = 1'b1; data4 = 8'(c);
        if (c <= 8) sb.push_back(8'(c));
      end else if (c == 10 * CPB + 1) begin
        wen4 = 1'b1; data4 = 8'hEE;
      end
      if (c == 8) begin
        check("t3_level7", level4, 7);
        check("t3_notfull", full4, 1'b0);
      end
      if (c == 9) begin
        check("t3_level8", level4, 8);
        check("t3_full", full4, 1'b1);
        check("t3_ovf_pre", ovf4, 1'b0);
      end
      if (c == 10) check("t3_ovf_pulse", ovf4, 1'b1);
      if (c == 11) check("t3_ovf_end", ovf4, 1'b0);
      if (c == 10 * CPB + 1) check("t4_full", full4, 1'b1);
      if (c == 10 * CPB + 2) begin
        check("t4_ovf_pulse", ovf4, 1'b1);
        check("t4_level7", level4, 7);
        check("t4_notfull", full4, 1'b0);
      end
      if (c == 10 * CPB + 3) check("t4_ovf_end", ovf4, 1'b0);
      tick();
    end
    wen4 = 1'b0;
    wait_idle4();

    // Reset in the DATA phase of 0x5A with three bytes queued.
    for (int c = 0; c <= 13; c++) begin
      wen4 = 1'b0;
      if (c <= 3) begin
        wen4 = 1'b1; data4 = (c == 0) ? 8'h5A : 8'(8'hB0 + c);
        sb.push_back(data4);
      end
      if (c == 12) begin
        check("t5_level_pre", level4, 3);
        rst = 1'b1;
        wen4 = 1'b1; data4 = 8'h77;
        sb.delete();
      end
      if (c == 13) begin
        rst = 1'b0;
        check("t5_tx", tx4, 1'b1);
        check("t5_level", level4, 0);
        check("t5_busy", busy4, 1'b0);
        check("t5_ovf", ovf4, 1'b0);
      end
      tick();
    end
    wen4 = 1'b1; data4 = 8'h01; sb.push_back(8'h01);
    tick();
    wen4 = 1'b0;
    wait_idle4();

    // Two clocks per bit on the second instance.
    for (int c = 0; c <= 10 * CPB2 + 2; c++) begin
      wen2 = (c == 0);
      data2 = 8'h96;
      check("t6_tx", tx2, exp_tx(8'h96, c, CPB2));
      check("t6_busy", busy2, (c >= 1 && c <= 10 * CPB2 + 1));
      tick();
    end

    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Simulation/FPGA UART transmitter serving the byte-store path of the memory stage: the store unit raises `wEn` with `data` when the core stores to the UART address (0xFFFF_FFFC). The block buffers bytes in a small FIFO and serializes them as 8N1 frames on `tx`. Status outputs let the core or bench detect back-pressure and dropped bytes.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data` in 8: byte to transmit; sampled when `wEn`=1.
- `wEn` in 1: write strobe, one byte per high cycle.
- `tx` out 1: serial line, idle high.
- `busy` out 1: FIFO non-empty or a frame in progress.
- `full` out 1: FIFO level == `FIFO_DEPTH`.
- `level` out $clog2(FIFO_DEPTH)+1: bytes currently in FIFO (not counting the byte being shifted).
- `overflow` out 1: one-cycle pulse, the cycle after a write was dropped.

## Operation
- Write accepted iff `wEn`=1 and `full`=0 in that cycle; `full` is derived from registered `level`, so a same-cycle pop does not make room for a write when full. Rejected write: byte discarded, `overflow` high in the next cycle only.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO non-empty: pop head into shift register, go START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, go DATA.
  - DATA: 8 bits, LSB first, each `CLKS_PER_BIT` cycles; 3-bit bit index; after bit 7, go STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On last stop cycle: FIFO non-empty → pop, go START (no idle gap); else go IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1, cleared on every state change; a bit ends when counter = `CLKS_PER_BIT`-1.
- `tx` driven from a register (glitch-free).
- FIFO: read/write pointers of $clog2(FIFO_DEPTH) bits wrapping naturally; `level` updates +1 (write only), −1 (pop only), unchanged (both or neither).
- `busy` = (state ≠ IDLE) | (`level` ≠ 0).

## Timing
- Reset values: `tx`=1, `busy`=0, `full`=0, `level`=0, `overflow`=0, state IDLE, pointers/counters 0.
- Latency, write in cycle 0 with idle/empty block: `level`=1 and `busy`=1 in cycle 1; pop at end of cycle 1; `tx` low from cycle 2.
- Frame = 10×`CLKS_PER_BIT` cycles; back-to-back frames contiguous.
- Reset mid-frame: next cycle `tx`=1, FIFO emptied, partial frame abandoned, no pulse on `overflow`.
- `wEn` during reset cycle ignored.

## Structure
- `uart_pkg`: FSM state encoding (IDLE/START/DATA/STOP), `UART_DATA_BITS`=8, `UART_START_LVL`=0, `UART_STOP_LVL`=1, `UART_TX_ADDR`=32'hFFFF_FFFC.
- One sub-module: `sync_fifo` (parameterized width/depth, push/pop, `level`, `full`, `empty`); FSM, baud counter and shifter live in `uart_tx`.

## Test plan
- `CLKS_PER_BIT`=4; write 0xA5 at cycle 0 → `tx` low cycles 2–5, data 1,0,1,0,0,1,0,1 over cycles 6–37, high 38–41; `busy` 1 in cycles 1–41, 0 at cycle 42.
- Writes 0x11, 0x22, 0x33 in cycles 0–2 → three contiguous frames, cycles 2–121, no idle high between stop and next start; decoded bytes 0x11, 0x22, 0x33.
- `FIFO_DEPTH`=8; writes of 0x00..0x09 in cycles 0–9 → `level` reaches 8 and `full`=1 at cycle 9, byte 0x09 dropped, `overflow`=1 in cycle 10 only; transmitted bytes exactly 0x00..0x08.
- Fill to full, write coincident with pop → write dropped, `overflow` pulses, `level` drops to 7.
- `rst` asserted in DATA state of frame 0x5A with 3 bytes queued → next cycle `tx`=1, `level`=0, `busy`=0; later write 0x01 transmits correctly.
- `CLKS_PER_BIT`=2 → each bit exactly 2 cycles; frame 20 cycles.
